// File: rtl/dma_spi_resp.sv
// dma_spi_resp: SPI mode-0 byte engine shared by the DMA SPI channel and
// Z80 port writes. One byte out on MOSI, one byte in from MISO, MSB first.
module dma_spi_resp #(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dma_req,
  input  logic [7:0]       dma_wrdata,
  output logic [7:0]       dma_rddata,
  output logic             dma_stb,
  input  logic             cpu_wr,
  input  logic [7:0]       cpu_data,
  output logic [7:0]       cpu_rddata,
  output logic             busy,
  input  logic [DIV_W-1:0] div,
  output logic             sck,
  output logic             mosi,
  input  logic             miso
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [3:0]       edge_q, edge_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       dma_rd_q, dma_rd_d;
  logic [7:0]       cpu_rd_q, cpu_rd_d;
  logic             sck_q, sck_d;
  logic             owner_cpu_q, owner_cpu_d;

  // State and datapath registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      edge_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      dma_rd_q    <= '0;
      cpu_rd_q    <= '0;
      sck_q       <= 1'b0;
      owner_cpu_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      edge_q      <= edge_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      dma_rd_q    <= dma_rd_d;
      cpu_rd_q    <= cpu_rd_d;
      sck_q       <= sck_d;
      owner_cpu_q <= owner_cpu_d;
    end
  end

  // Next-state logic: request arbitration, SCK divider and bit shifting.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    edge_d      = edge_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    dma_rd_d    = dma_rd_q;
    cpu_rd_d    = cpu_rd_q;
    sck_d       = sck_q;
    owner_cpu_d = owner_cpu_q;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_wr || dma_req) begin
          tx_d        = cpu_wr ? cpu_data : dma_wrdata;
          owner_cpu_d = cpu_wr;
          div_d       = div;
          cnt_d       = div;
          edge_d      = '0;
          rx_d        = '0;
          sck_d       = 1'b0;
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          cnt_d  = div_q;
          sck_d  = ~sck_q;
          edge_d = edge_q + 4'd1;
          if (!sck_q) begin
            rx_d = {rx_q[6:0], miso};
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
          end
          // The 16th toggle is a falling edge, so rx_q already holds all
          // eight sampled bits; hand it over as DONE is entered.
          if (edge_q == 4'd15) begin
            state_d = S_DONE;
            if (owner_cpu_q) begin
              cpu_rd_d = rx_q;
            end else begin
              dma_rd_d = rx_q;
            end
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_GAP;
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dma_stb    = (state_q == S_DONE) && !owner_cpu_q;
  assign busy       = (state_q != S_IDLE);
  assign mosi       = (state_q == S_SHIFT) ? tx_q[7] : 1'b1;
  assign sck        = sck_q;
  assign dma_rddata = dma_rd_q;
  assign cpu_rddata = cpu_rd_q;

endmodule
